// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - fetch-to-ID issue FIFO with load-use bubble and redirect flush; perf counters under ISSUE_PERF_EN
module issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] issue_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             ld_pending;
    logic [4:0]       ld_rd;
    state_t           state;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [31:0] head_instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign head_instr = mem_instr[rd_ptr];
    assign opcode     = head_instr[6:0];
    assign rs1        = head_instr[19:15];
    assign rs2        = head_instr[24:20];
    assign uses_rs1   = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2   = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BR);
    assign hazard     = ld_pending && (ld_rd != 5'd0) &&
                        ((uses_rs1 && (rs1 == ld_rd)) || (uses_rs2 && (rs2 == ld_rd)));

    assign if_ready = !full && (state != FLUSH) && !flush;
    assign id_valid = !empty && !hazard && (state != FLUSH) && !flush;
    assign stall_o  = (state == RUN) && !empty && hazard && !flush;
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;
    assign id_instr = empty ? 32'd0 : head_instr;
    assign id_pc    = empty ? 32'd0 : mem_pc[rd_ptr];

    // FIFO storage; contents are masked by empty so they need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= if_instr;
            mem_pc[wr_ptr]    <= if_pc;
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Last-issued load tracking; held while the pipeline is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pending <= 1'b0;
            ld_rd      <= 5'd0;
        end else if (flush) begin
            ld_pending <= 1'b0;
        end else if (id_ready) begin
            if (pop && (opcode == OP_LOAD)) begin
                ld_pending <= 1'b1;
                ld_rd      <= head_instr[11:7];
            end else begin
                ld_pending <= 1'b0;
            end
        end
    end

    // Issue state: one bubble cycle after a load-use hit, one dead cycle after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else if (flush) begin
            state <= FLUSH;
        end else begin
            case (state)
                RUN:     state <= (!empty && hazard && id_ready) ? STALL : RUN;
                STALL:   state <= RUN;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef ISSUE_PERF_EN
    logic [31:0] issue_q;
    logic [31:0] bubble_q;

    // Performance counters; survive flushes, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (pop)     issue_q  <= issue_q + 32'd1;
            if (stall_o) bubble_q <= bubble_q + 32'd1;
        end
    end

    assign issue_cnt  = issue_q;
    assign bubble_cnt = bubble_q;
`else
    assign issue_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;

`ifdef ISSUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X5  = 32'h00228333;
    localparam logic [31:0] ADD_X0  = 32'h00200333;
    localparam logic [31:0] LUI_X5  = 32'h000282B7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        flush;
    logic        stall_o;
    logic [31:0] issue_cnt;
    logic [31:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .flush      (flush),
        .stall_o    (stall_o),
        .issue_cnt  (issue_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        id_ready = 1'b1; flush = 1'b0;
        #3;
        n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_o); end
        n_cmp++; if (id_instr !== 32'd0) begin n_bad++; $display("FAIL reset_id_instr got %h want 0", id_instr); end
        n_cmp++; if (id_pc !== 32'd0) begin n_bad++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        n_cmp++; if (issue_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_counters got %0d/%0d want 0/0", issue_cnt, bubble_cnt); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h0;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_bad++; $display("FAIL basic_if_ready got %0b want 1", if_ready); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_bypass got %0b want 0", id_valid); end
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL basic_id_valid got %0b want 1", id_valid); end
        n_cmp++; if (id_instr !== 32'h00500093) begin n_bad++; $display("FAIL basic_id_instr got %h want 00500093", id_instr); end
        n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL basic_id_pc got %h want 0", id_pc); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL basic_stall got %0b want 0", stall_o); end
        tick();
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained got %0b want 0", id_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1;
            if_instr = 32'h00000093 | (32'(i) << 20);
            if_pc    = 32'h100 + 32'(4 * i);
            #1;
            n_cmp++; if (if_ready !== (i < 4)) begin
                n_bad++; $display("FAIL fill_if_ready[%0d] got %0b want %0b", i, if_ready, (i < 4)); end
            tick();
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_instr = 32'h00000093 | (32'(i) << 20);
            exp_pc    = 32'h100 + 32'(4 * i);
            #1;
            n_cmp++; if (id_valid !== 1'b1 || id_instr !== exp_instr || id_pc !== exp_pc) begin
                n_bad++; $display("FAIL fill_order[%0d] got v=%0b %h@%h want v=1 %h@%h",
                                  i, id_valid, id_instr, id_pc, exp_instr, exp_pc); end
            tick();
        end
        #1;
        n_cmp++; if (id_valid !== 1'b0 || id_instr !== 32'd0) begin
            n_bad++; $display("FAIL fill_empty got v=%0b %h want v=0 0", id_valid, id_instr); end
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = LW_X5; if_pc = 32'h200;
        tick();
        if_instr = ADD_X5; if_pc = 32'h204;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== LW_X5) begin
            n_bad++; $display("FAIL lu_load_issue got v=%0b %h want v=1 %h", id_valid, id_instr, LW_X5); end
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || stall_o !== 1'b1) begin
            n_bad++; $display("FAIL lu_bubble got v=%0b s=%0b want v=0 s=1", id_valid, stall_o); end
        tick();
        #1;
        n_cmp++; if (id_valid !== 1'b1 || stall_o !== 1'b0 || id_instr !== ADD_X5 || id_pc !== 32'h204) begin
            n_bad++; $display("FAIL lu_after got v=%0b s=%0b %h@%h want v=1 s=0 %h@204",
                              id_valid, stall_o, id_instr, id_pc, ADD_X5); end
        n_cmp++; if (bubble_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            n_bad++; $display("FAIL lu_bubble_cnt got %0d want %0d", bubble_cnt, PERF ? 1 : 0); end
        n_cmp++; if (issue_cnt !== (PERF ? 32'd6 : 32'd0)) begin
            n_bad++; $display("FAIL lu_issue_cnt got %0d want %0d", issue_cnt, PERF ? 6 : 0); end
        tick();
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL lu_drained got %0b want 0", id_valid); end
    endtask

    task automatic test_no_bubble();
        if_valid = 1'b1; if_instr = LW_X0; if_pc = 32'h240;
        tick();
        if_instr = ADD_X0; if_pc = 32'h244;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || stall_o !== 1'b0 || id_instr !== ADD_X0) begin
            n_bad++; $display("FAIL nb_rd0 got v=%0b s=%0b %h want v=1 s=0 %h", id_valid, stall_o, id_instr, ADD_X0); end
        tick();
        if_valid = 1'b1; if_instr = LW_X5; if_pc = 32'h250;
        tick();
        if_instr = LUI_X5; if_pc = 32'h254;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || stall_o !== 1'b0 || id_instr !== LUI_X5) begin
            n_bad++; $display("FAIL nb_lui got v=%0b s=%0b %h want v=1 s=0 %h", id_valid, stall_o, id_instr, LUI_X5); end
        tick();
        #1;
        n_cmp++; if (bubble_cnt !== (PERF ? 32'd1 : 32'd0) || issue_cnt !== (PERF ? 32'd11 : 32'd0)) begin
            n_bad++; $display("FAIL nb_counters got %0d/%0d want %0d/%0d",
                              issue_cnt, bubble_cnt, PERF ? 11 : 0, PERF ? 1 : 0); end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_instr = 32'h00100113 + 32'(i); if_pc = 32'h280 + 32'(4 * i);
            tick();
        end
        flush = 1'b1; if_instr = 32'hDEADBEEF; if_pc = 32'h28C;
        #1;
        n_cmp++; if (if_ready !== 1'b0 || id_valid !== 1'b0 || stall_o !== 1'b0) begin
            n_bad++; $display("FAIL fl_cycle got r=%0b v=%0b s=%0b want 0 0 0", if_ready, id_valid, stall_o); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (if_ready !== 1'b0 || id_valid !== 1'b0) begin
            n_bad++; $display("FAIL fl_state got r=%0b v=%0b want 0 0", if_ready, id_valid); end
        tick();
        if_instr = 32'h00700193; if_pc = 32'h300;
        #1;
        n_cmp++; if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_bad++; $display("FAIL fl_resume got r=%0b v=%0b want 1 0", if_ready, id_valid); end
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_instr !== 32'h00700193 || id_pc !== 32'h300) begin
            n_bad++; $display("FAIL fl_first got v=%0b %h@%h want v=1 00700193@300", id_valid, id_instr, id_pc); end
        n_cmp++; if (issue_cnt !== (PERF ? 32'd11 : 32'd0)) begin
            n_bad++; $display("FAIL fl_issue_cnt got %0d want %0d", issue_cnt, PERF ? 11 : 0); end
        tick();
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL fl_empty got %0b want 0", id_valid); end
    endtask

    task automatic test_async_reset();
        if_valid = 1'b1; if_instr = LW_X5; if_pc = 32'h400;
        tick();
        if_instr = ADD_X5; if_pc = 32'h404;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL ar_pre_stall got %0b want 1", stall_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || stall_o !== 1'b0 || if_ready !== 1'b1) begin
            n_bad++; $display("FAIL ar_ctrl got v=%0b s=%0b r=%0b want 0 0 1", id_valid, stall_o, if_ready); end
        n_cmp++; if (id_instr !== 32'd0 || id_pc !== 32'd0 || issue_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            n_bad++; $display("FAIL ar_data got %h %h %0d %0d want 0 0 0 0", id_instr, id_pc, issue_cnt, bubble_cnt); end
        tick();
        rst_n = 1'b1;
        if_valid = 1'b1; if_instr = ADD_X5; if_pc = 32'h500;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || stall_o !== 1'b0 || id_instr !== ADD_X5 || id_pc !== 32'h500) begin
            n_bad++; $display("FAIL ar_first got v=%0b s=%0b %h@%h want v=1 s=0 %h@500",
                              id_valid, stall_o, id_instr, id_pc, ADD_X5); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_load_use();
        test_no_bubble();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
